// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin arbiter with a registered one-hot grant and handoff without idle cycles.
// Define RR_ARB_TIMEOUT_EN to force a handoff after MAX_HOLD cycles when another requester is waiting.
module rr_arbiter_n #(
    parameter int N        = 5,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic                 gnt_valid,
    output logic [$clog2(N)-1:0] gnt_id
);
    localparam int         IW        = $clog2(N);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state, w_stateNext;
    logic [N-1:0]  r_gnt, w_gntNext;
    logic          r_valid, w_validNext;
    logic [IW-1:0] r_id, w_idNext;
    logic [IW-1:0] r_ptr, w_ptrNext;
    logic [7:0]    r_hcnt, w_hcntNext;

    logic [N-1:0]  w_cand;
    logic [N-1:0]  w_pickOneHot;
    logic [IW-1:0] w_pick;
    logic          w_found;
    logic          w_ownerReq;
    logic          w_timeout;

    // The current owner is never a candidate, so a hold-time revoke always moves the grant elsewhere.
    assign w_cand     = req & ~r_gnt;
    assign w_ownerReq = |(req & r_gnt);

`ifdef RR_ARB_TIMEOUT_EN
    logic w_othersReq;
    assign w_othersReq = |w_cand;
    assign w_timeout   = (r_state == BUSY) && (r_hcnt == HOLD_LAST) && w_othersReq;
`else
    assign w_timeout   = 1'b0;
`endif

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_cand[(int'(r_ptr) + k) % N]) begin
                w_found = 1'b1;
                w_pick  = IW'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_pickOneHot = {{(N-1){1'b0}}, 1'b1} << w_pick;

    always_comb begin
        w_stateNext = r_state;
        w_gntNext   = r_gnt;
        w_validNext = r_valid;
        w_idNext    = r_id;
        w_ptrNext   = r_ptr;
        w_hcntNext  = r_hcnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_stateNext = BUSY;
                    w_gntNext   = w_pickOneHot;
                    w_validNext = 1'b1;
                    w_idNext    = w_pick;
                    w_ptrNext   = (w_pick == IW'(N - 1)) ? '0 : w_pick + 1'b1;
                    w_hcntNext  = '0;
                end
            end
            BUSY: begin
                if (!w_ownerReq || w_timeout) begin
                    if (w_found) begin
                        w_gntNext   = w_pickOneHot;
                        w_validNext = 1'b1;
                        w_idNext    = w_pick;
                        w_ptrNext   = (w_pick == IW'(N - 1)) ? '0 : w_pick + 1'b1;
                        w_hcntNext  = '0;
                    end else begin
                        w_stateNext = IDLE;
                        w_gntNext   = '0;
                        w_validNext = 1'b0;
                        w_idNext    = '0;
                        w_hcntNext  = '0;
                    end
                end else if (r_hcnt != HOLD_LAST) begin
                    w_hcntNext = r_hcnt + 8'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_gntNext   = '0;
                w_validNext = 1'b0;
                w_idNext    = '0;
                w_hcntNext  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_gnt   <= w_gntNext;
            r_valid <= w_validNext;
            r_id    <= w_idNext;
            r_ptr   <= w_ptrNext;
            r_hcnt  <= w_hcntNext;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_valid;
    assign gnt_id    = r_id;

endmodule
